// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator: key codes, operator and state
// encodings, the operand register bundle and key classification helpers.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    op_e        op;
    logic       a_set;
    logic       b_set;
  } operand_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  function automatic op_e key_to_op(input logic [3:0] k);
    op_e op;
    case (k)
      KEY_SUB: op = OP_SUB;
      KEY_MUL: op = OP_MUL;
      KEY_DIV: op = OP_DIV;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/calc_timeout_cnt.sv
// Watchdog for the datapath handshake: counts enabled cycles from a synchronous
// clear and holds at TIMEOUT-1, flagging expiry while it sits there.
module calc_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/calc_ctrl.sv
// Sequencing FSM of the 4-bit calculator: collects operands and operator from
// the keypad, runs the shared datapath handshake and holds the result for display.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic [1:0] dp_op,
  output logic       dp_start,
  input  logic       dp_done,
  input  logic [7:0] dp_result,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err,
  output logic       busy
);

  state_e     state, state_n;
  operand_t   regs, regs_n;
  logic [7:0] result_n;
  logic       err_n;
  logic       valid_n;
  logic       start;
  logic       in_wait;
  logic       expired;

  logic key_dig, key_op, key_eq, key_clr;

  assign key_dig = key_valid && is_digit(key_code);
  assign key_op  = key_valid && is_op(key_code);
  assign key_eq  = key_valid && (key_code == KEY_EQ);
  assign key_clr = key_valid && (key_code == KEY_CLR);

  assign in_wait = (state == S_WAIT);

  calc_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_A;
      regs         <= '0;
      result       <= '0;
      err          <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_n;
      regs         <= regs_n;
      result       <= result_n;
      err          <= err_n;
      result_valid <= valid_n;
    end
  end

  // NOTE: every signal assigned below gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n  = state;
    regs_n   = regs;
    result_n = result;
    err_n    = err;
    valid_n  = 1'b0;
    start    = 1'b0;

    case (state)
      S_A: begin
        if (key_dig) begin
          regs_n.a     = key_code;
          regs_n.a_set = 1'b1;
        end else if (key_op && regs.a_set) begin
          regs_n.op    = key_to_op(key_code);
          regs_n.b_set = 1'b0;
          state_n      = S_B;
        end else if (key_clr) begin
          regs_n = '0;
        end
      end

      S_B: begin
        if (key_dig) begin
          regs_n.b     = key_code;
          regs_n.b_set = 1'b1;
        end else if (key_op) begin
          regs_n.op = key_to_op(key_code);
        end else if (key_eq && regs.b_set) begin
          state_n = S_EXEC;
        end else if (key_clr) begin
          regs_n  = '0;
          state_n = S_A;
        end
      end

      S_EXEC: begin
        if ((regs.op == OP_DIV) && (regs.b == 4'd0)) begin
          result_n = '0;
          err_n    = 1'b1;
          valid_n  = 1'b1;
          state_n  = S_SHOW;
        end else begin
          start   = 1'b1;
          state_n = S_WAIT;
        end
      end

      S_WAIT: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (dp_done) begin
          result_n = dp_result;
          err_n    = 1'b0;
          valid_n  = 1'b1;
          state_n  = S_SHOW;
        end else if (expired) begin
          result_n = '0;
          err_n    = 1'b1;
          valid_n  = 1'b1;
          state_n  = S_SHOW;
        end
      end

      S_SHOW: begin
        if (key_dig) begin
          regs_n.a     = key_code;
          regs_n.a_set = 1'b1;
          regs_n.b_set = 1'b0;
          result_n     = '0;
          err_n        = 1'b0;
          state_n      = S_A;
        end else if (key_op) begin
          // Chaining only works when the last result fits a 4-bit operand.
          if (!err && (result <= 8'd15)) begin
            regs_n.a     = result[3:0];
            regs_n.a_set = 1'b1;
            regs_n.op    = key_to_op(key_code);
            regs_n.b_set = 1'b0;
            result_n     = '0;
            err_n        = 1'b0;
            state_n      = S_B;
          end else begin
            err_n = 1'b1;
          end
        end else if (key_clr) begin
          regs_n   = '0;
          result_n = '0;
          err_n    = 1'b0;
          state_n  = S_A;
        end
      end

      default: begin
        regs_n   = '0;
        result_n = '0;
        err_n    = 1'b0;
        state_n  = S_A;
      end
    endcase
  end

  assign dp_a     = regs.a;
  assign dp_b     = regs.b;
  assign dp_op    = regs.op;
  assign dp_start = start;
  assign busy     = (state == S_EXEC) || in_wait;

endmodule
